// File: rtl/pwm_duty_capture.sv
// ---------------------------------------------------------------------------
// pwm_duty_capture
//
// Receive-side duty-cycle recovery for an external PWM waveform. PWM_In is
// synchronised to sysclk. The high time H and the period P are then measured
// between consecutive rising edges. The duty cycle floor(H*100/P) is computed
// with a restoring shift-subtract divider that produces one quotient bit per
// cycle. The result uses the same 7-bit 0..100 format that the duty
// generators drive.
//
// Ports
//   sysclk        in   system clock, rising edge
//   Reset         in   synchronous active-high reset
//   Enable_SW_1   in   capture enable; low clears everything but the synchroniser
//   PWM_In        in   asynchronous PWM input
//   Duty_Output   out  [6:0] last computed duty, 0..100 percent
//   Duty_Valid    out  one-cycle pulse when Duty_Output updates
//   Period_Count  out  [CNT_W-1:0] period (sysclk cycles) of the last result
//   Overrun       out  one-cycle pulse when an edge is dropped during a divide
// ---------------------------------------------------------------------------
module pwm_duty_capture #(
    parameter int CNT_W       = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic             sysclk,
    input  logic             Reset,
    input  logic             Enable_SW_1,
    input  logic             PWM_In,
    output logic [6:0]       Duty_Output,
    output logic             Duty_Valid,
    output logic [CNT_W-1:0] Period_Count,
    output logic             Overrun
);

    // Numerator H*100 needs 7 extra bits because 100 < 128.
    localparam int                NUM_W     = CNT_W + 7;
    localparam int                ITER_W    = $clog2(NUM_W);
    localparam logic [CNT_W-1:0]  CNT_MAX   = {CNT_W{1'b1}};
    localparam logic [ITER_W-1:0] ITER_LAST = ITER_W'(NUM_W - 1);
    localparam logic [NUM_W-1:0]  PCT_SCALE = NUM_W'(100);
    localparam logic [6:0]        PCT_FULL  = 7'd100;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_MEASURE = 2'd1,
        ST_DIVIDE  = 2'd2
    } state_t;

    logic [SYNC_STAGES-1:0] sync_r;
    logic                   sync_d_r;
    state_t                 state_r,       state_nx_s;
    logic [CNT_W-1:0]       period_cnt_r,  period_cnt_nx_s;
    logic [CNT_W-1:0]       high_cnt_r,    high_cnt_nx_s;
    logic                   timed_out_r,   timed_out_nx_s;
    logic [NUM_W-1:0]       num_r,         num_nx_s;
    logic [CNT_W-1:0]       rem_r,         rem_nx_s;
    logic [CNT_W-1:0]       den_r,         den_nx_s;
    logic [ITER_W-1:0]      iter_r,        iter_nx_s;
    logic [6:0]             duty_r,        duty_nx_s;
    logic                   valid_r,       valid_nx_s;
    logic [CNT_W-1:0]       period_out_r,  period_out_nx_s;
    logic                   overrun_r,     overrun_nx_s;

    logic                   sync_s;
    logic                   edge_s;
    logic                   clear_s;
    logic                   timeout_s;
    logic [CNT_W+NUM_W-1:0] step_s;

    // One restoring-division step. Returns {remainder, numerator shifted
    // left with the new quotient bit in the LSB}. The borrow out of the
    // trial subtraction decides the quotient bit.
    function automatic logic [CNT_W+NUM_W-1:0] div_step(
        input logic [CNT_W-1:0] rem,
        input logic [NUM_W-1:0] num,
        input logic [CNT_W-1:0] den
    );
        logic [CNT_W:0]         trial;
        logic [CNT_W:0]         diff;
        logic [CNT_W+NUM_W-1:0] res;
        trial = {rem, num[NUM_W-1]};
        diff  = trial - {1'b0, den};
        if (diff[CNT_W] == 1'b0) begin
            res = {diff[CNT_W-1:0], num[NUM_W-2:0], 1'b1};
        end else begin
            res = {trial[CNT_W-1:0], num[NUM_W-2:0], 1'b0};
        end
        return res;
    endfunction

    // Clamp a full-width quotient to the 0..100 output range.
    function automatic logic [6:0] pct_clamp(input logic [NUM_W-1:0] q);
        logic [6:0] res;
        if (q > PCT_SCALE) begin
            res = PCT_FULL;
        end else begin
            res = q[6:0];
        end
        return res;
    endfunction

    assign sync_s    = sync_r[SYNC_STAGES-1];
    assign edge_s    = sync_s & ~sync_d_r;
    assign clear_s   = Reset | ~Enable_SW_1;
    // Fires once per saturation; timed_out_r blocks repeats until the next edge.
    assign timeout_s = (period_cnt_r == CNT_MAX) & ~timed_out_r;

    // Input synchroniser and edge-detect delay; only Reset clears them, so
    // sampling continues while capture is disabled.
    always_ff @(posedge sysclk) begin
        if (Reset) begin
            sync_r   <= {SYNC_STAGES{1'b0}};
            sync_d_r <= 1'b0;
        end else begin
            sync_r   <= {sync_r[SYNC_STAGES-2:0], PWM_In};
            sync_d_r <= sync_s;
        end
    end

    // Next-state, counter, divider and output computation.
    always_comb begin
        state_nx_s      = state_r;
        period_cnt_nx_s = period_cnt_r;
        high_cnt_nx_s   = high_cnt_r;
        timed_out_nx_s  = timed_out_r;
        num_nx_s        = num_r;
        rem_nx_s        = rem_r;
        den_nx_s        = den_r;
        iter_nx_s       = iter_r;
        duty_nx_s       = duty_r;
        valid_nx_s      = 1'b0;
        period_out_nx_s = period_out_r;
        overrun_nx_s    = 1'b0;
        step_s          = div_step(rem_r, num_r, den_r);

        // Counters run in every state. An edge restarts both at 1, so at
        // the next edge they hold exactly P and H.
        if (edge_s) begin
            period_cnt_nx_s = CNT_W'(1);
            high_cnt_nx_s   = CNT_W'(1);
            timed_out_nx_s  = 1'b0;
        end else begin
            if (period_cnt_r != CNT_MAX) begin
                period_cnt_nx_s = period_cnt_r + CNT_W'(1);
            end else begin
                period_cnt_nx_s = period_cnt_r;
            end
            if (sync_s && (high_cnt_r != CNT_MAX)) begin
                high_cnt_nx_s = high_cnt_r + CNT_W'(1);
            end else begin
                high_cnt_nx_s = high_cnt_r;
            end
        end

        case (state_r)
            ST_IDLE: begin
                // The first edge only opens a period; nothing to capture yet.
                if (edge_s) begin
                    state_nx_s = ST_MEASURE;
                end else if (timeout_s) begin
                    duty_nx_s       = sync_s ? PCT_FULL : 7'd0;
                    period_out_nx_s = CNT_MAX;
                    valid_nx_s      = 1'b1;
                    timed_out_nx_s  = 1'b1;
                    state_nx_s      = ST_IDLE;
                end else begin
                    state_nx_s = ST_IDLE;
                end
            end
            ST_MEASURE: begin
                // An edge takes priority over a simultaneous timeout.
                if (edge_s) begin
                    num_nx_s   = NUM_W'(high_cnt_r) * PCT_SCALE;
                    den_nx_s   = period_cnt_r;
                    rem_nx_s   = CNT_W'(0);
                    iter_nx_s  = ITER_W'(0);
                    state_nx_s = ST_DIVIDE;
                end else if (timeout_s) begin
                    duty_nx_s       = sync_s ? PCT_FULL : 7'd0;
                    period_out_nx_s = CNT_MAX;
                    valid_nx_s      = 1'b1;
                    timed_out_nx_s  = 1'b1;
                    state_nx_s      = ST_IDLE;
                end else begin
                    state_nx_s = ST_MEASURE;
                end
            end
            ST_DIVIDE: begin
                // Edges during the divide are dropped and flagged. A timeout
                // waits until MEASURE is re-entered.
                overrun_nx_s = edge_s;
                rem_nx_s     = step_s[CNT_W+NUM_W-1:NUM_W];
                num_nx_s     = step_s[NUM_W-1:0];
                if (iter_r == ITER_LAST) begin
                    duty_nx_s       = pct_clamp(step_s[NUM_W-1:0]);
                    period_out_nx_s = den_r;
                    valid_nx_s      = 1'b1;
                    iter_nx_s       = ITER_W'(0);
                    state_nx_s      = ST_MEASURE;
                end else begin
                    iter_nx_s  = iter_r + ITER_W'(1);
                    state_nx_s = ST_DIVIDE;
                end
            end
            default: begin
                state_nx_s = ST_IDLE;
            end
        endcase
    end

    // State and datapath registers; Reset or a low enable discards everything,
    // including a divide in progress.
    always_ff @(posedge sysclk) begin
        if (clear_s) begin
            state_r      <= ST_IDLE;
            period_cnt_r <= CNT_W'(0);
            high_cnt_r   <= CNT_W'(0);
            timed_out_r  <= 1'b0;
            num_r        <= NUM_W'(0);
            rem_r        <= CNT_W'(0);
            den_r        <= CNT_W'(0);
            iter_r       <= ITER_W'(0);
            duty_r       <= 7'd0;
            valid_r      <= 1'b0;
            period_out_r <= CNT_W'(0);
            overrun_r    <= 1'b0;
        end else begin
            state_r      <= state_nx_s;
            period_cnt_r <= period_cnt_nx_s;
            high_cnt_r   <= high_cnt_nx_s;
            timed_out_r  <= timed_out_nx_s;
            num_r        <= num_nx_s;
            rem_r        <= rem_nx_s;
            den_r        <= den_nx_s;
            iter_r       <= iter_nx_s;
            duty_r       <= duty_nx_s;
            valid_r      <= valid_nx_s;
            period_out_r <= period_out_nx_s;
            overrun_r    <= overrun_nx_s;
        end
    end

    assign Duty_Output  = duty_r;
    assign Duty_Valid   = valid_r;
    assign Period_Count = period_out_r;
    assign Overrun      = overrun_r;

endmodule

// File: tb/tb_pwm_duty_capture.sv
// ---------------------------------------------------------------------------
// tb_pwm_duty_capture
//
// Two instances share one clock: a CNT_W=16 unit for the measurement, divide
// and overrun behaviour, and a CNT_W=8 unit for the DC-low/DC-high timeout.
// The 16-bit unit is scored against a period-level model. Each driven rising
// edge either opens a measurement, is dropped as an overrun (within NW cycles
// of the last accepted edge), or yields floor(100*H/P) for the period that
// just ended.
// ---------------------------------------------------------------------------
module tb_pwm_duty_capture;

    localparam int CW   = 16;
    localparam int CW8  = 8;
    localparam int NW16 = CW + 7;
    localparam int NONE = 1000000;

    typedef struct {
        int duty;
        int per;
    } exp_t;

    logic sysclk = 1'b0;
    always #5 sysclk = ~sysclk;

    logic          rst16, en16, pwm16, val16, ovr16;
    logic [6:0]    duty16;
    logic [CW-1:0] per16;
    logic           rst8, en8, pwm8, val8, ovr8;
    logic [6:0]     duty8;
    logic [CW8-1:0] per8;

    pwm_duty_capture #(.CNT_W(CW), .SYNC_STAGES(2)) dut (
        .sysclk(sysclk), .Reset(rst16), .Enable_SW_1(en16), .PWM_In(pwm16),
        .Duty_Output(duty16), .Duty_Valid(val16), .Period_Count(per16), .Overrun(ovr16)
    );

    pwm_duty_capture #(.CNT_W(CW8), .SYNC_STAGES(2)) dut8 (
        .sysclk(sysclk), .Reset(rst8), .Enable_SW_1(en8), .PWM_In(pwm8),
        .Duty_Output(duty8), .Duty_Valid(val8), .Period_Count(per8), .Overrun(ovr8)
    );

    int   checks = 0;
    int   errors = 0;
    exp_t exp_q[$];
    bit   armed, have_acc, mon16, chk8_on;
    int   mt, last_acc, cur_p, cur_h, exp_ovr, exp_val, ovr_seen, val_seen;
    int   val8_cnt, last_duty8, last_per8;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
        end
    endtask

    task automatic tick();
        @(posedge sysclk);
        #1;
    endtask

    // Model: a rising edge at model time mt closes the period (cur_p, cur_h).
    task automatic model_edge();
        exp_t e;
        if (!armed) begin
            armed = 1'b1;
        end else if (have_acc && ((mt - last_acc) <= NW16)) begin
            exp_ovr++;
        end else begin
            e.per  = cur_p;
            e.duty = (cur_h * 100) / cur_p;
            if (e.duty > 100) e.duty = 100;
            exp_q.push_back(e);
            exp_val++;
            last_acc = mt;
            have_acc = 1'b1;
        end
    endtask

    task automatic model_clear();
        exp_val  = exp_val - exp_q.size();
        exp_q.delete();
        armed    = 1'b0;
        have_acc = 1'b0;
    endtask

    // One PWM period on the 16-bit unit, with an optional reset or disable
    // window placed at a cycle offset inside it.
    task automatic drive_period(input int p, input int h, input int rst_off, input int dis_off);
        model_edge();
        cur_p = p;
        cur_h = h;
        pwm16 = 1'b1;
        for (int k = 0; k < p; k++) begin
            if (k == h) pwm16 = 1'b0;
            if (k == rst_off) begin
                rst16 = 1'b1;
                model_clear();
            end
            if (k == rst_off + 1) begin
                rst16 = 1'b0;
                chk("rst_mid_div_duty", 32'(duty16), 32'd0);
                chk("rst_mid_div_period", 32'(per16), 32'd0);
                chk("rst_mid_div_valid", 32'(val16), 32'd0);
            end
            if (k == dis_off) begin
                en16 = 1'b0;
                model_clear();
            end
            if (k == dis_off + 1) chk("disable_duty_zero", 32'(duty16), 32'd0);
            if (k == dis_off + 20) en16 = 1'b1;
            tick();
        end
        mt += p;
    endtask

    // Scoreboard monitors, sampled on the falling edge.
    always @(negedge sysclk) begin
        exp_t e;
        if (mon16) begin
            if (ovr16 === 1'b1) ovr_seen++;
            if (val16 === 1'b1) begin
                val_seen++;
                chk("valid16_expected", 32'(exp_q.size() != 0), 32'd1);
                if (exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    chk("duty16", 32'(duty16), e.duty);
                    chk("period16", 32'(per16), e.per);
                end
            end
        end
        if (val8 === 1'b1) begin
            val8_cnt++;
            last_duty8 = int'(duty8);
            last_per8  = int'(per8);
            if (chk8_on) begin
                chk("duty8_recover", 32'(duty8), 32'd50);
                chk("period8_recover", 32'(per8), 32'd200);
            end
        end
    end

    initial begin
        int v0, n, p, h;
        bit got;
        rst16 = 1'b1; rst8 = 1'b1; en16 = 1'b1; en8 = 1'b1;
        pwm16 = 1'b0; pwm8 = 1'b0; mon16 = 1'b0; chk8_on = 1'b0;
        armed = 1'b0; have_acc = 1'b0; mt = 0; last_acc = 0; cur_p = 1; cur_h = 0;
        exp_ovr = 0; exp_val = 0; ovr_seen = 0; val_seen = 0;
        val8_cnt = 0; last_duty8 = -1; last_per8 = -1;
        repeat (3) tick();
        rst16 = 1'b0; rst8 = 1'b0;
        tick();
        chk("reset_duty16", 32'(duty16), 32'd0);
        chk("reset_valid16", 32'(val16), 32'd0);
        chk("reset_period16", 32'(per16), 32'd0);
        chk("reset_overrun16", 32'(ovr16), 32'd0);
        chk("reset_duty8", 32'(duty8), 32'd0);
        chk("reset_valid8", 32'(val8), 32'd0);
        chk("reset_period8", 32'(per8), 32'd0);
        chk("reset_overrun8", 32'(ovr8), 32'd0);
        mon16 = 1'b1;
        repeat (20) tick();

        // Steady 25 %, period 100: five results, no overrun.
        for (int i = 0; i < 6; i++) drive_period(100, 25, NONE, NONE);
        chk("pct25_overruns", ovr_seen, 32'd0);
        chk("pct25_valids", val_seen, 32'd5);

        // Truncation cases.
        for (int i = 0; i < 3; i++) drive_period(300, 100, NONE, NONE);
        for (int i = 0; i < 3; i++) drive_period(300, 299, NONE, NONE);

        // Period shorter than the divide: edges inside DIVIDE are dropped.
        for (int i = 0; i < 20; i++) drive_period(10, 5, NONE, NONE);
        chk("short_overruns_model", ovr_seen, exp_ovr);
        chk("short_overruns_seen", 32'(ovr_seen > 0), 32'd1);

        // Random periods and high times.
        for (int i = 0; i < 40; i++) begin
            p = int'($urandom_range(80, 2));
            h = int'($urandom_range(p - 1, 1));
            drive_period(p, h, NONE, NONE);
        end

        // Reset for one cycle inside the divide of the third edge.
        for (int i = 0; i < 6; i++) drive_period(100, 10, (i == 2) ? 18 : NONE, NONE);

        // Enable low for 20 cycles during steady 40 %.
        for (int i = 0; i < 5; i++) drive_period(100, 40, NONE, (i == 1) ? 50 : NONE);

        // Closing edge, then drain the last divide.
        model_edge();
        pwm16 = 1'b1;
        repeat (5) tick();
        pwm16 = 1'b0;
        repeat (60) tick();
        chk("final_overruns", ovr_seen, exp_ovr);
        chk("final_pending", exp_q.size(), 32'd0);
        chk("final_valids", val_seen, exp_val);
        chk("final_duty16_40", 32'(duty16), 32'd40);

        // CNT_W=8: input held low from reset times out to 0 %.
        rst8 = 1'b1; pwm8 = 1'b0;
        tick();
        rst8 = 1'b0;
        v0 = val8_cnt; got = 1'b0; n = 0;
        for (int i = 0; i < 400 && !got; i++) begin
            tick();
            if (val8_cnt != v0) begin
                got = 1'b1;
                n = i;
            end
        end
        chk("dc_low_seen", 32'(got), 32'd1);
        chk("dc_low_duty", last_duty8, 32'd0);
        chk("dc_low_period", last_per8, 32'd255);
        chk("dc_low_latency_window", 32'((n >= 250) && (n <= 262)), 32'd1);
        repeat (300) tick();
        chk("dc_low_single_pulse", val8_cnt - v0, 32'd1);

        // Input held high from reset times out to 100 %.
        rst8 = 1'b1; pwm8 = 1'b0;
        tick();
        rst8 = 1'b0; pwm8 = 1'b1;
        v0 = val8_cnt; got = 1'b0;
        for (int i = 0; i < 400 && !got; i++) begin
            tick();
            if (val8_cnt != v0) got = 1'b1;
        end
        chk("dc_high_seen", 32'(got), 32'd1);
        chk("dc_high_duty", last_duty8, 32'd100);
        chk("dc_high_period", last_per8, 32'd255);
        repeat (300) tick();
        chk("dc_high_single_pulse", val8_cnt - v0, 32'd1);

        // Recovery to a 50 %, period-200 waveform.
        pwm8 = 1'b0;
        repeat (50) tick();
        chk8_on = 1'b1;
        v0 = val8_cnt;
        for (int i = 0; i < 4; i++) begin
            pwm8 = 1'b1;
            repeat (100) tick();
            pwm8 = 1'b0;
            repeat (100) tick();
        end
        pwm8 = 1'b1;
        repeat (5) tick();
        pwm8 = 1'b0;
        repeat (40) tick();
        chk8_on = 1'b0;
        chk("recover_valid_count", val8_cnt - v0, 32'd4);
        chk("recover_last_duty", last_duty8, 32'd50);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
